// File: rtl/buffer_lru_kv_pkg.sv
// Shared encodings for the key/value replacement buffer: request opcodes and
// replacement-policy selectors.
package buffer_lru_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP     = 2'd0,
        OP_INSERT     = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    localparam int POL_LRU  = 0;
    localparam int POL_FIFO = 1;

endpackage

// File: rtl/buffer_lru_kv_if.sv
// Request/response bus of the replacement buffer. Handshake: a transfer happens
// on any rising edge where valid and ready are both high; valid never waits on ready.
interface buffer_lru_kv_if #(
    parameter int KEY_W  = 16,
    parameter int DATA_W = 16
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [KEY_W-1:0]  req_key_i;
    logic [DATA_W-1:0] req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_hit_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_evict_o;
    logic [KEY_W-1:0]  rsp_evict_key_o;
    logic [DATA_W-1:0] rsp_evict_data_o;

    modport master (
        output req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o,
               rsp_evict_o, rsp_evict_key_o, rsp_evict_data_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o,
               rsp_evict_o, rsp_evict_key_o, rsp_evict_data_o
    );
endinterface

// File: rtl/buffer_lru_kv_age.sv
// Age permutation for the replacement buffer: touch makes an entry newest,
// demote makes it oldest; the age-0 entry is reported as the replacement candidate.
module lru_age_ctrl #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          touch_i,
    input  logic          demote_i,
    input  logic [AW-1:0] idx_i,
    output logic [AW-1:0] oldest_o
);
    logic [AW-1:0] age_q [DEPTH];
    logic [AW-1:0] age_d [DEPTH];

    // Shifting only the entries on one side of the old age keeps a permutation.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) age_d[i] = AW'(i);
        end else if (touch_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (AW'(i) == idx_i)              age_d[i] = AW'(DEPTH - 1);
                else if (age_q[i] > age_q[idx_i]) age_d[i] = age_q[i] - AW'(1);
            end
        end else if (demote_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (AW'(i) == idx_i)              age_d[i] = '0;
                else if (age_q[i] < age_q[idx_i]) age_d[i] = age_q[i] + AW'(1);
            end
        end
    end

    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] == '0) oldest_o = AW'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= AW'(i);
        end else begin
            age_q <= age_d;
        end
    end
endmodule

// File: rtl/buffer_lru_kv.sv
// Keyed replacement buffer with LRU/FIFO policy, eviction reporting and a
// one-deep response register behind a valid/ready request port.
module buffer_lru_kv
    import buffer_lru_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 16,
    parameter int DATA_W = 16,
    parameter int POLICY = POL_LRU
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    buffer_lru_kv_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q;
    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [OW-1:0]     occ_q;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_evict_q, rsp_evict_d;
    logic [KEY_W-1:0]  rsp_ekey_q, rsp_ekey_d;
    logic [DATA_W-1:0] rsp_edata_q, rsp_edata_d;

    logic          hit, any_free, req_ready, accept;
    logic [AW-1:0] hit_idx, free_idx, oldest, victim, age_idx, wr_idx;
    logic          touch, demote, wr_en, clr_en, occ_inc, occ_dec;
    op_e           op;

    assign op = op_e'(bus.req_op_i);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && key_q[i] == bus.req_key_i) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = AW'(i);
            end
        end
    end

    assign victim    = any_free ? free_idx : oldest;
    assign req_ready = !flush_i && (!rsp_valid_q || bus.rsp_ready_i);
    assign accept    = bus.req_valid_i && req_ready;

    always_comb begin
        touch       = 1'b0;
        demote      = 1'b0;
        age_idx     = hit_idx;
        wr_en       = 1'b0;
        wr_idx      = hit_idx;
        clr_en      = 1'b0;
        occ_inc     = 1'b0;
        occ_dec     = 1'b0;
        rsp_valid_d = bus.rsp_ready_i ? 1'b0 : rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_data_d  = rsp_data_q;
        rsp_evict_d = rsp_evict_q;
        rsp_ekey_d  = rsp_ekey_q;
        rsp_edata_d = rsp_edata_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = hit;
            rsp_data_d  = hit ? data_q[hit_idx] : '0;
            rsp_evict_d = 1'b0;
            rsp_ekey_d  = '0;
            rsp_edata_d = '0;
            case (op)
                OP_LOOKUP: touch = hit && (POLICY == POL_LRU);
                OP_INSERT: begin
                    wr_en = 1'b1;
                    if (hit) begin
                        touch = (POLICY == POL_LRU);
                    end else begin
                        wr_idx      = victim;
                        age_idx     = victim;
                        touch       = 1'b1;
                        occ_inc     = !valid_q[victim];
                        rsp_evict_d = valid_q[victim];
                        if (valid_q[victim]) begin
                            rsp_ekey_d  = key_q[victim];
                            rsp_edata_d = data_q[victim];
                        end
                    end
                end
                OP_INVALIDATE: begin
                    clr_en  = hit;
                    demote  = hit;
                    occ_dec = hit;
                end
                default: ;
            endcase
        end
    end

    lru_age_ctrl #(.DEPTH(DEPTH)) u_age (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .touch_i  (touch),
        .demote_i (demote),
        .idx_i    (age_idx),
        .oldest_o (oldest)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            occ_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_evict_q <= 1'b0;
            rsp_ekey_q  <= '0;
            rsp_edata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
                key_q[wr_idx]   <= bus.req_key_i;
                data_q[wr_idx]  <= bus.req_data_i;
            end else if (clr_en) begin
                valid_q[hit_idx] <= 1'b0;
            end
            if (flush_i)      occ_q <= '0;
            else if (occ_inc) occ_q <= occ_q + OW'(1);
            else if (occ_dec) occ_q <= occ_q - OW'(1);
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
            rsp_evict_q <= rsp_evict_d;
            rsp_ekey_q  <= rsp_ekey_d;
            rsp_edata_q <= rsp_edata_d;
        end
    end

    assign bus.req_ready_o      = req_ready;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_hit_o        = rsp_hit_q;
    assign bus.rsp_data_o       = rsp_data_q;
    assign bus.rsp_evict_o      = rsp_evict_q;
    assign bus.rsp_evict_key_o  = rsp_ekey_q;
    assign bus.rsp_evict_data_o = rsp_edata_q;
    assign occupancy_o          = occ_q;
endmodule

// File: tb/tb_buffer_lru_kv.sv
// Bench for buffer_lru_kv: a 4-entry LRU unit and a 4-entry FIFO unit driven with
// directed requests; responses are checked against an expected queue per unit.
module tb_buffer_lru_kv;
    import buffer_lru_pkg::*;

    localparam int RW = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic [1:0]  req_op    [2];
    logic [15:0] req_key   [2];
    logic [15:0] req_data  [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [RW-1:0] act     [2];
    logic [2:0]  occ       [2];

    logic [RW-1:0] exp_q0[$];
    logic [RW-1:0] exp_q1[$];
    int checks = 0;
    int errors = 0;
    int rsp_n  = 0;
    int waits;

    buffer_lru_kv_if #(.KEY_W(16), .DATA_W(16)) if0 ();
    buffer_lru_kv_if #(.KEY_W(16), .DATA_W(16)) if1 ();

    buffer_lru_kv #(.DEPTH(4), .KEY_W(16), .DATA_W(16), .POLICY(POL_LRU)) dut_lru (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if0), .occupancy_o(occ[0])
    );
    buffer_lru_kv #(.DEPTH(4), .KEY_W(16), .DATA_W(16), .POLICY(POL_FIFO)) dut_fifo (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if1), .occupancy_o(occ[1])
    );

    assign if0.req_valid_i = req_valid[0];
    assign if0.req_op_i    = req_op[0];
    assign if0.req_key_i   = req_key[0];
    assign if0.req_data_i  = req_data[0];
    assign if0.rsp_ready_i = rsp_ready[0];
    assign if1.req_valid_i = req_valid[1];
    assign if1.req_op_i    = req_op[1];
    assign if1.req_key_i   = req_key[1];
    assign if1.req_data_i  = req_data[1];
    assign if1.rsp_ready_i = rsp_ready[1];
    assign req_ready[0] = if0.req_ready_o;
    assign req_ready[1] = if1.req_ready_o;
    assign rsp_valid[0] = if0.rsp_valid_o;
    assign rsp_valid[1] = if1.rsp_valid_o;
    assign act[0] = {if0.rsp_hit_o, if0.rsp_data_o, if0.rsp_evict_o, if0.rsp_evict_key_o, if0.rsp_evict_data_o};
    assign act[1] = {if1.rsp_hit_o, if1.rsp_data_o, if1.rsp_evict_o, if1.rsp_evict_key_o, if1.rsp_evict_data_o};

    function automatic logic [RW-1:0] mk(input logic h, input logic [15:0] d, input logic ev,
                                         input logic [15:0] ek, input logic [15:0] ed);
        return {h, d, ev, ek, ed};
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int u, input logic [1:0] op, input logic [15:0] key,
                        input logic [15:0] data, input logic [RW-1:0] e, input bit push,
                        output int n);
        n = 0;
        req_valid[u] = 1'b1;
        req_op[u]    = op;
        req_key[u]   = key;
        req_data[u]  = data;
        #1;
        while (!req_ready[u]) begin
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout u%0d key %h got no ready, required ready", u, key);
                req_valid[u] = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        if (push) begin
            if (u == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    task automatic go(input int u, input logic [1:0] op, input logic [15:0] key,
                      input logic [15:0] data, input logic [RW-1:0] e);
        int n;
        send(u, op, key, data, e, 1'b1, n);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (rsp_valid[u] && rsp_ready[u]) begin
                    logic [RW-1:0] e;
                    rsp_n++;
                    if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected u%0d #%0d got %h required none", u, rsp_n, act[u]);
                    end else begin
                        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        checks++;
                        if (act[u] !== e) begin
                            errors++;
                            $display("FAIL rsp u%0d #%0d got %h required %h", u, rsp_n, act[u], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_op[u]    = 2'd0;
            req_key[u]   = '0;
            req_data[u]  = '0;
            rsp_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_occ0", 32'(occ[0]), 32'd0);
        chk("reset_occ1", 32'(occ[1]), 32'd0);
        chk("reset_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
        go(0, OP_LOOKUP, 16'h0000, 16'h0, mk(0, 0, 0, 0, 0));

        flush = 1'b1;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        chk("flush_ready0", 32'(req_ready[0]), 32'd0);
        chk("flush_ready1", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        chk("flush_occ0", 32'(occ[0]), 32'd0);

        for (int u = 0; u < 2; u++) begin
            for (int k = 1; k <= 4; k++) go(u, OP_INSERT, 16'(k), 16'(16'hA0 + k), mk(0, 0, 0, 0, 0));
        end
        chk("full_occ0", 32'(occ[0]), 32'd4);
        chk("full_occ1", 32'(occ[1]), 32'd4);

        go(0, OP_LOOKUP, 16'd1, 16'h0, mk(1, 16'hA1, 0, 0, 0));
        go(0, OP_INSERT, 16'd5, 16'hA5, mk(0, 0, 1, 16'd2, 16'hA2));
        chk("lru_evict_occ", 32'(occ[0]), 32'd4);
        go(1, OP_LOOKUP, 16'd1, 16'h0, mk(1, 16'hA1, 0, 0, 0));
        go(1, OP_INSERT, 16'd5, 16'hA5, mk(0, 0, 1, 16'd1, 16'hA1));
        chk("fifo_evict_occ", 32'(occ[1]), 32'd4);

        go(0, OP_INSERT, 16'd3, 16'hBB, mk(1, 16'hA3, 0, 0, 0));
        go(0, OP_LOOKUP, 16'd3, 16'h0, mk(1, 16'hBB, 0, 0, 0));
        go(0, OP_RSVD,   16'd4, 16'h0, mk(1, 16'hA4, 0, 0, 0));
        go(0, OP_INSERT, 16'd6, 16'hA6, mk(0, 0, 1, 16'd4, 16'hA4));
        chk("rsvd_evict_occ", 32'(occ[0]), 32'd4);

        go(1, OP_INVALIDATE, 16'd2, 16'h0, mk(1, 16'hA2, 0, 0, 0));
        chk("inval_occ", 32'(occ[1]), 32'd3);
        go(1, OP_INSERT, 16'd9, 16'hC9, mk(0, 0, 0, 0, 0));
        chk("refill_occ", 32'(occ[1]), 32'd4);
        go(1, OP_INVALIDATE, 16'd7, 16'h0, mk(0, 0, 0, 0, 0));
        chk("inval_miss_occ", 32'(occ[1]), 32'd4);
        go(1, OP_LOOKUP, 16'd2, 16'h0, mk(0, 0, 0, 0, 0));
        go(1, OP_LOOKUP, 16'd9, 16'h0, mk(1, 16'hC9, 0, 0, 0));
        go(1, OP_INSERT, 16'd6, 16'hA6, mk(0, 0, 1, 16'd3, 16'hA3));

        @(negedge clk);
        rsp_ready[0] = 1'b0;
        go(0, OP_LOOKUP, 16'd5, 16'h0, mk(1, 16'hA5, 0, 0, 0));
        req_valid[0] = 1'b1;
        req_op[0]    = OP_LOOKUP;
        req_key[0]   = 16'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready[0]), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_rsp_hit_data", 32'(act[0][RW-1 -: 17]), {15'd0, 1'b1, 16'hA5});
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        send(0, OP_LOOKUP, 16'd6, 16'h0, mk(1, 16'hA6, 0, 0, 0), 1'b1, waits);
        chk("tput_wait0", 32'(waits), 32'd0);
        send(0, OP_LOOKUP, 16'd1, 16'h0, mk(1, 16'hA1, 0, 0, 0), 1'b1, waits);
        chk("tput_wait1", 32'(waits), 32'd0);
        send(0, OP_LOOKUP, 16'd3, 16'h0, mk(1, 16'hBB, 0, 0, 0), 1'b1, waits);
        chk("tput_wait2", 32'(waits), 32'd0);
        send(0, OP_LOOKUP, 16'd8, 16'h0, mk(0, 0, 0, 0, 0), 1'b1, waits);
        chk("tput_wait3", 32'(waits), 32'd0);

        @(negedge clk);
        rsp_ready[1] = 1'b0;
        send(1, OP_LOOKUP, 16'd9, 16'h0, '0, 1'b0, waits);
        chk("pre_reset_valid", 32'(rsp_valid[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_valid", 32'(rsp_valid[1]), 32'd0);
        chk("mid_reset_occ", 32'(occ[1]), 32'd0);
        chk("mid_reset_rsp", 32'(act[1][RW-1 -: 17]), 32'd0);
        rst = 1'b0;
        rsp_ready[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("drain_q0", 32'(exp_q0.size()), 32'd0);
        chk("drain_q1", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/buffer_lru_kv.md
# buffer_lru_kv

Parametrised key/value replacement buffer: the next generation of the team's single-port LRU value buffer. It adds keyed lookup with hit/data return, explicit invalidate, a flush, a selectable LRU/FIFO policy, eviction reporting and a valid/ready request/response handshake. It sits between a request source (e.g. a front-end translation or tag path) and a backing store, which consumes the eviction reports.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥2.
- `KEY_W`, 16: key width.
- `DATA_W`, 16: payload width.
- `POLICY`, 0: 0 = LRU (hits refresh age), 1 = FIFO (age is set only on allocation).
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `flush_i` in 1: invalidate all entries.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_op_i` in 2: 0 = LOOKUP, 1 = INSERT, 2 = INVALIDATE, 3 = reserved (treated as LOOKUP with no state change).
- `req_key_i` in `KEY_W`: request key.
- `req_data_i` in `DATA_W`: INSERT payload.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when `rsp_valid_o && rsp_ready_i`.
- `rsp_hit_o` out 1: key was present before the operation.
- `rsp_data_o` out `DATA_W`: stored payload on a hit, otherwise 0.
- `rsp_evict_o` out 1: INSERT displaced a valid entry.
- `rsp_evict_key_o` out `KEY_W`: key of the displaced entry.
- `rsp_evict_data_o` out `DATA_W`: payload of the displaced entry.
- `occupancy_o` out `$clog2(DEPTH+1)`: number of valid entries.

## Operation
- **Per-entry state:** `valid`, `key`, `data`, `age` (`$clog2(DEPTH)` bits).
  - Ages always form a permutation of 0..DEPTH-1.
  - Age 0 is oldest; age DEPTH-1 is newest.
- **Match:** a valid entry whose key equals `req_key_i`. At most one entry matches, guaranteed by the INSERT-hit rule.
- **Victim:** the lowest-index invalid entry; if all entries are valid, the entry with age 0.
- **Touch(e):**
  - `age[e] <= DEPTH-1`.
  - Every entry with `age > old age[e]` decrements.
- **Demote(e):**
  - `age[e] <= 0`.
  - Every entry with `age < old age[e]` increments.
- **LOOKUP:**
  - Hit: return data; Touch when POLICY = 0.
  - Miss: `rsp_hit_o` = 0, no state change.
- **INSERT, hit:**
  - Overwrite data; Touch when POLICY = 0.
  - `rsp_hit_o` = 1, `rsp_data_o` = old data, no eviction.
- **INSERT, miss:**
  - Write key/data/valid into the victim, then Touch it.
  - `rsp_evict_*` reports the victim's previous contents if it was valid.
- **INVALIDATE:**
  - Hit: clear valid, Demote, `rsp_hit_o` = 1, `rsp_data_o` = old data.
  - Miss: no state change.
- **flush_i:**
  - Clears all valid bits; ages return to reset order.
  - Does not touch the response register.
  - Forces `req_ready_o` = 0 in that cycle (flush wins over a simultaneous request).
- **Occupancy:**
  - +1 on INSERT into an invalid slot.
  - −1 on INVALIDATE hit.
  - 0 on flush or reset.
  - Unchanged on INSERT with eviction.

## Timing
- **Handshake:**
  - `req_ready_o = !flush_i && (!rsp_valid_o || rsp_ready_i)`; one-deep response register, full throughput.
  - An accepted request updates entry state at the same edge that loads the response.
  - The response is valid the next cycle (latency 1).
- **Response stability:** all `rsp_*` outputs are held stable while `rsp_valid_o && !rsp_ready_i`.
- **Back-to-back requests:** a request accepted in cycle N+1 sees the state written by request N.
- **Reset values:**
  - `valid` = 0, `age[i]` = i, key/data = 0.
  - `rsp_valid_o` = 0 and all `rsp_*` outputs = 0.
  - `occupancy_o` = 0.
- **Reset mid-operation:** any pending response is dropped.

## Structure
- **Package `buffer_lru_pkg`:**
  - op encodings (`OP_LOOKUP`, `OP_INSERT`, `OP_INVALIDATE`)
  - policy constants (`POL_LRU`, `POL_FIFO`)
- **Sub-module `lru_age_ctrl`:**
  - holds the age array
  - takes touch/demote strobes plus an index
  - outputs the age-0 index
- **Top level:** key/data/valid storage, match and victim logic, response register.

## Test plan
- **Reset/flush:** reset, then LOOKUP 0x0000 → `rsp_hit_o` = 0, occupancy 0. Flush asserted together with `req_valid_i` → `req_ready_o` = 0.
- **Fill and evict, DEPTH = 4, LRU:**
  - INSERT keys 1..4 (data 0xA1..0xA4), LOOKUP 1, INSERT 5.
  - Expect eviction of key 2 / 0xA2; occupancy stays 4.
- **Same sequence, POLICY = 1 (FIFO):** INSERT 5 evicts key 1 / 0xA1.
- **INSERT hit:** INSERT key 3 with 0xBB over 0xA3 → hit = 1, data = 0xA3, no eviction; a later LOOKUP 3 → 0xBB.
- **INVALIDATE:**
  - INVALIDATE 2 on a full buffer → hit = 1, occupancy 3.
  - Next INSERT 9 fills the freed slot with no eviction.
  - INVALIDATE of an absent key → hit = 0.
- **Backpressure:** hold `rsp_ready_i` = 0 for 3 cycles with `req_valid_i` = 1 → `req_ready_o` = 0 and the response is unchanged. Releasing it → one request accepted per cycle.
